// File: rtl/fft32_bitrev_reorder.sv
// Output reorder stage for the 32-point SDF FFT: ping-pong buffer written in
// bit-reversed order, read in natural order. Optional macro FFT_OUT_SCALE_EN adds divide-by-N.
module fft32_bitrev_reorder #(
  parameter int DW = 18,
  parameter int N  = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_r,
  input  logic [DW-1:0] in_i,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_r,
  output logic [DW-1:0] out_i,
  output logic [4:0]    out_idx,
  output logic          out_last,
  output logic          ovf_err
);

  localparam logic [4:0] LAST = 5'(N - 1);

  logic [2*DW-1:0] mem [2][N];
  logic [1:0]      full;
  logic            wbank;
  logic            rbank;
  logic [4:0]      wcnt;
  logic [4:0]      rcnt;
  logic            ovf_q;
  logic            wr_fire;
  logic            rd_fire;
  logic [2*DW-1:0] rd_word;
  logic [DW-1:0]   rd_r;
  logic [DW-1:0]   rd_i;

  function automatic logic [4:0] bitrev5(input logic [4:0] a);
    return {a[0], a[1], a[2], a[3], a[4]};
  endfunction

  // Valid/ready: a transfer happens on a rising edge where both valid and
  // ready are high; ready never depends combinationally on valid.
  assign in_ready  = !full[wbank];
  assign out_valid = full[rbank];
  assign wr_fire   = in_valid && in_ready;
  assign rd_fire   = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (wr_fire) mem[wbank][bitrev5(wcnt)] <= {in_r, in_i};
  end

  // Write completion and read completion always target different banks,
  // so both flag updates can land in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      full  <= 2'b00;
      wbank <= 1'b0;
      rbank <= 1'b0;
      wcnt  <= 5'd0;
      rcnt  <= 5'd0;
      ovf_q <= 1'b0;
    end else begin
      if (in_valid && !in_ready) ovf_q <= 1'b1;
      if (wr_fire) begin
        wcnt <= wcnt + 5'd1;
        if (wcnt == LAST) begin
          full[wbank] <= 1'b1;
          wbank       <= !wbank;
        end
      end
      if (rd_fire) begin
        rcnt <= rcnt + 5'd1;
        if (rcnt == LAST) begin
          full[rbank] <= 1'b0;
          rbank       <= !rbank;
        end
      end
    end
  end

  assign rd_word = mem[rbank][rcnt];

`ifdef FFT_OUT_SCALE_EN
  // Round-half-up divide by 32, done one bit wider so the +16 cannot wrap.
  function automatic logic [DW-1:0] scale(input logic [DW-1:0] x);
    logic signed [DW:0] w;
    w = {x[DW-1], x} + (DW+1)'(16);
    w = w >>> 5;
    return w[DW-1:0];
  endfunction

  assign rd_r = scale(rd_word[2*DW-1:DW]);
  assign rd_i = scale(rd_word[DW-1:0]);
`else
  assign rd_r = rd_word[2*DW-1:DW];
  assign rd_i = rd_word[DW-1:0];
`endif

  assign out_r    = out_valid ? rd_r : '0;
  assign out_i    = out_valid ? rd_i : '0;
  assign out_idx  = rcnt;
  assign out_last = (rcnt == LAST);
  assign ovf_err  = ovf_q;

endmodule

// File: tb/tb_fft32_bitrev_reorder.sv
// Bench for fft32_bitrev_reorder: cycle-level reference model built from frame
// queues (natural-order frames appended when the 32nd sample arrives).
module tb_fft32_bitrev_reorder;

  localparam int DW = 18;
  localparam int W  = 2*DW + 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_r;
  logic [DW-1:0] in_i;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_r;
  logic [DW-1:0] out_i;
  logic [4:0]    out_idx;
  logic          out_last;
  logic          ovf_err;

  fft32_bitrev_reorder #(.DW(DW), .N(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_r(in_r), .in_i(in_i),
    .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r), .out_i(out_i),
    .out_idx(out_idx), .out_last(out_last), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Scoreboard entries: {k, re, im} of every sample still owed downstream.
  logic [W-1:0]    exp_q[$];
  logic [2*DW-1:0] wbuf[32];
  int              wcount = 0;
  logic            exp_ovf = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int bitrev(input int n);
    int r;
    r = 0;
    for (int b = 0; b < 5; b++) if ((n >> b) & 1) r += 1 << (4 - b);
    return r;
  endfunction

  function automatic logic [DW-1:0] post(input logic [DW-1:0] x);
`ifdef FFT_OUT_SCALE_EN
    int v;
    v = int'($signed(x));
    v = (v + 16) >>> 5;
    return DW'(v);
`else
    return x;
`endif
  endfunction

  // One clock: check outputs against the model, drive inputs, advance the model.
  task automatic cycle(input logic iv, input logic [DW-1:0] r, input logic [DW-1:0] i,
                       input logic ordy);
    int         pend;
    logic       rdy_e;
    logic       val_e;
    logic [W-1:0] h;
    pend  = (exp_q.size() + 31) / 32;
    rdy_e = (pend < 2);
    val_e = (exp_q.size() > 0);
    in_valid  = iv;
    in_r      = r;
    in_i      = i;
    out_ready = ordy;
    check("in_ready", 64'(in_ready), 64'(rdy_e));
    check("out_valid", 64'(out_valid), 64'(val_e));
    check("ovf_err", 64'(ovf_err), 64'(exp_ovf));
    if (val_e) begin
      h = exp_q[0];
      check("out_idx", 64'(out_idx), 64'(h[W-1 -: 5]));
      check("out_last", 64'(out_last), 64'(h[W-1 -: 5] == 5'd31));
      check("out_r", 64'(out_r), 64'(post(h[2*DW-1:DW])));
      check("out_i", 64'(out_i), 64'(post(h[DW-1:0])));
    end else begin
      check("out_r_idle", 64'(out_r), 64'd0);
    end
    if (iv && !rdy_e) exp_ovf = 1'b1;
    if (ordy && val_e) void'(exp_q.pop_front());
    if (iv && rdy_e) begin
      wbuf[wcount] = {r, i};
      wcount++;
      if (wcount == 32) begin
        for (int k = 0; k < 32; k++) exp_q.push_back({5'(k), wbuf[bitrev(k)]});
        wcount = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    wcount  = 0;
    exp_ovf = 1'b0;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_ovf_err", 64'(ovf_err), 64'd0);
    check("rst_out_idx", 64'(out_idx), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
  endtask

  task automatic drain();
    for (int c = 0; c < 200 && exp_q.size() > 0; c++) cycle(1'b0, '0, '0, 1'b1);
  endtask

  task automatic rand_sample(input logic ordy);
    cycle(1'b1, DW'($urandom), DW'($urandom), ordy);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_r = '0;
    in_i = '0;
    @(posedge clk);
    #1;
    do_reset();

    // Bit-reversed ramp: output must come out as k*64 / -k*64.
    for (int n = 0; n < 32; n++)
      cycle(1'b1, DW'(bitrev(n) * 64), DW'(-(bitrev(n) * 64)), 1'b1);
    drain();

    // Four back-to-back frames with downstream always ready.
    for (int n = 0; n < 128; n++) rand_sample(1'b1);
    drain();

    // Backpressure: 64 accepted, the 65th is dropped and flags overflow.
    for (int n = 0; n < 65; n++) rand_sample(1'b0);
    cycle(1'b0, '0, '0, 1'b0);
    drain();

    // Stall for 5 cycles with sample 10 presented.
    do_reset();
    for (int n = 0; n < 32; n++) rand_sample(1'b0);
    for (int c = 0; c < 10; c++) cycle(1'b0, '0, '0, 1'b1);
    for (int c = 0; c < 5; c++) cycle(1'b0, '0, '0, 1'b0);
    drain();

    // Reset with 20 writes into a new frame and 5 reads of the previous one.
    for (int n = 0; n < 32; n++) rand_sample(1'b0);
    for (int n = 0; n < 20; n++) rand_sample(n < 5);
    do_reset();
    for (int n = 0; n < 32; n++) rand_sample(1'b1);
    drain();

    // Randomized traffic with both sides throttling.
    for (int c = 0; c < 800; c++)
      cycle($urandom_range(0, 3) != 0, DW'($urandom), DW'($urandom), $urandom_range(0, 3) != 0);
    drain();

`ifdef FFT_OUT_SCALE_EN
    begin
      logic [DW-1:0] xr[32];
      do_reset();
      for (int k = 0; k < 32; k++) xr[k] = DW'($urandom);
      xr[0] = DW'(48);
      xr[1] = DW'(-48);
      xr[2] = DW'(15);
      xr[3] = DW'(-131072);
      for (int n = 0; n < 32; n++) cycle(1'b1, xr[bitrev(n)], xr[bitrev(n)], 1'b0);
      check("scale_x0", 64'(out_r), 64'(DW'(2)));
      for (int c = 0; c < 3; c++) cycle(1'b0, '0, '0, 1'b1);
      check("scale_x3", 64'(out_r), 64'(DW'(-4096)));
      drain();
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
